// File: rtl/ibex_wb_stage.sv
// Single-entry writeback stage: holds one retiring instruction and drives the
// ALU/CSR and LSU register-file write channels, stalling ID/EX on loads/stores.
module ibex_wb_stage #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_wb_i,
  input  logic [1:0]           instr_type_wb_i,
  input  logic [4:0]           rf_waddr_id_i,
  input  logic [DataWidth-1:0] rf_wdata_id_i,
  input  logic                 rf_we_id_i,
  output logic                 ready_wb_o,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  input  logic [DataWidth-1:0] rf_wdata_lsu_i,
  output logic [4:0]           rf_waddr_wb_o,
  output logic [DataWidth-1:0] rf_wdata_wb_o,
  output logic                 rf_we_wb_o,
  output logic [DataWidth-1:0] rf_wdata_lsu_o,
  output logic                 rf_we_lsu_o,
  output logic                 outstanding_lsu_o,
  output logic                 instr_done_wb_o,
  output logic                 lsu_err_wb_o,
  output logic [CntWidth-1:0]  instr_cnt_o
);

  localparam logic [1:0] TypeAlu   = 2'b00;
  localparam logic [1:0] TypeLoad  = 2'b01;
  localparam logic [1:0] TypeStore = 2'b10;

  typedef enum logic [1:0] {
    EMPTY,
    RETIRE,
    LSU_WAIT
  } wb_state_e;

  wb_state_e            state_q, state_d;
  logic [1:0]           type_q;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 we_q;
  logic [CntWidth-1:0]  instr_cnt_q;
  logic                 done;
  logic                 capture;
  logic                 is_lsu_type;

  assign done        = (state_q == RETIRE) | ((state_q == LSU_WAIT) & lsu_resp_valid_i);
  assign capture     = en_wb_i & ready_wb_o;
  assign is_lsu_type = (instr_type_wb_i == TypeLoad) | (instr_type_wb_i == TypeStore);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q      <= TypeAlu;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      if (capture) begin
        type_q  <= instr_type_wb_i;
        waddr_q <= rf_waddr_id_i;
        wdata_q <= rf_wdata_id_i;
        we_q    <= rf_we_id_i;
      end
      if (done) begin
        instr_cnt_q <= instr_cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
      end
    end
  end

  // A retiring instruction and a newly captured one can share a cycle, so
  // capture takes priority over the drop to EMPTY.
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = is_lsu_type ? LSU_WAIT : RETIRE;
    end else if (done) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    ready_wb_o        = (state_q == EMPTY) | done;
    rf_we_wb_o        = (state_q == RETIRE) & we_q & (waddr_q != 5'd0);
    rf_wdata_wb_o     = (type_q == TypeLoad) ? '0 : wdata_q;
    rf_we_lsu_o       = (state_q == LSU_WAIT) & (type_q == TypeLoad) & we_q &
                        lsu_resp_valid_i & ~lsu_resp_err_i & (waddr_q != 5'd0);
    // Load data bypasses straight through; only reset forces it quiet.
    rf_wdata_lsu_o    = rst_i ? '0 : rf_wdata_lsu_i;
    rf_waddr_wb_o     = (state_q != EMPTY) ? waddr_q : 5'd0;
    outstanding_lsu_o = (state_q == LSU_WAIT);
    instr_done_wb_o   = done;
    lsu_err_wb_o      = (state_q == LSU_WAIT) & lsu_resp_valid_i & lsu_resp_err_i;
    instr_cnt_o       = instr_cnt_q;
  end

endmodule

// File: tb/tb_ibex_wb_stage.sv
// Self-checking bench for ibex_wb_stage: per-scenario tasks plus a write
// scoreboard fed when stimulus is driven and drained when the DUT writes.
module tb_ibex_wb_stage;

  logic        clk_i;
  logic        rst_i;
  logic        en_wb_i;
  logic [1:0]  instr_type_wb_i;
  logic [4:0]  rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic        rf_we_id_i;
  logic        ready_wb_o;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;
  logic [31:0] rf_wdata_lsu_i;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        rf_we_wb_o;
  logic [31:0] rf_wdata_lsu_o;
  logic        rf_we_lsu_o;
  logic        outstanding_lsu_o;
  logic        instr_done_wb_o;
  logic        lsu_err_wb_o;
  logic [31:0] instr_cnt_o;

  typedef struct {
    bit          lsu;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  ibex_wb_stage #(.DataWidth(32), .CntWidth(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .en_wb_i          (en_wb_i),
    .instr_type_wb_i  (instr_type_wb_i),
    .rf_waddr_id_i    (rf_waddr_id_i),
    .rf_wdata_id_i    (rf_wdata_id_i),
    .rf_we_id_i       (rf_we_id_i),
    .ready_wb_o       (ready_wb_o),
    .lsu_resp_valid_i (lsu_resp_valid_i),
    .lsu_resp_err_i   (lsu_resp_err_i),
    .rf_wdata_lsu_i   (rf_wdata_lsu_i),
    .rf_waddr_wb_o    (rf_waddr_wb_o),
    .rf_wdata_wb_o    (rf_wdata_wb_o),
    .rf_we_wb_o       (rf_we_wb_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .outstanding_lsu_o(outstanding_lsu_o),
    .instr_done_wb_o  (instr_done_wb_o),
    .lsu_err_wb_o     (lsu_err_wb_o),
    .instr_cnt_o      (instr_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Every RF write seen mid-cycle must match the oldest expected write.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rf_we_wb_o || rf_we_lsu_o) begin
        checks++;
        if (rf_we_wb_o && rf_we_lsu_o) begin
          errors++;
          $display("[TB] FAIL both_channels: wb_we=%0b lsu_we=%0b, required at most one", rf_we_wb_o, rf_we_lsu_o);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: lsu=%0b addr=%0d, required no write", rf_we_lsu_o, rf_waddr_wb_o);
        end else begin
          wr_t e;
          logic [31:0] data;
          e = exp_q.pop_front();
          data = rf_we_lsu_o ? rf_wdata_lsu_o : rf_wdata_wb_o;
          if (rf_we_lsu_o !== e.lsu || rf_waddr_wb_o !== e.addr || data !== e.data) begin
            errors++;
            $display("[TB] FAIL sb_write: got lsu=%0b addr=%0d data=%h, required lsu=%0b addr=%0d data=%h",
                     rf_we_lsu_o, rf_waddr_wb_o, data, e.lsu, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] typ, input logic [4:0] addr,
                       input logic [31:0] data, input logic we);
    en_wb_i         = en;
    instr_type_wb_i = typ;
    rf_waddr_id_i   = addr;
    rf_wdata_id_i   = data;
    rf_we_id_i      = we;
  endtask

  task automatic respond(input logic valid, input logic err, input logic [31:0] data);
    lsu_resp_valid_i = valid;
    lsu_resp_err_i   = err;
    rf_wdata_lsu_i   = data;
  endtask

  task automatic test_reset();
    checks++;
    if (ready_wb_o !== 1'b1 || instr_cnt_o !== 32'd0 || outstanding_lsu_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: ready=%0b cnt=%0d outst=%0b, required 1/0/0", ready_wb_o, instr_cnt_o, outstanding_lsu_o);
    end
    cyc();
    rst_i = 1'b0;
    cyc();
    drive(1'b1, 2'b00, 5'd3, 32'hAB, 1'b1);
    respond(1'b0, 1'b0, 32'hFFFF_0000);
    cyc();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (rf_we_wb_o !== 1'b0 || rf_waddr_wb_o !== 5'd0 || rf_wdata_wb_o !== 32'd0 ||
        rf_wdata_lsu_o !== 32'd0 || instr_done_wb_o !== 1'b0 || ready_wb_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_async: we=%0b addr=%0d wdata=%h lsudata=%h done=%0b ready=%0b, required 0/0/0/0/0/1",
               rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_wdata_lsu_o, instr_done_wb_o, ready_wb_o);
    end
    cyc();
    rst_i = 1'b0;
    respond(1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (ready_wb_o !== 1'b1 || instr_cnt_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%0b cnt=%0d, required 1/0", ready_wb_o, instr_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs[3];
    logic [31:0] datas[3];
    addrs = '{5'd5, 5'd6, 5'd7};
    datas = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i < 3) begin
        drive(1'b1, 2'b00, addrs[i], datas[i], 1'b1);
        exp_q.push_back('{lsu: 1'b0, addr: addrs[i], data: datas[i]});
        exp_cnt++;
      end else begin
        drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
      end
      @(negedge clk_i);
      if (i < 3) begin
        checks++;
        if (ready_wb_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_ready[%0d]: got %0b, required 1", i, ready_wb_o);
        end
      end
      if (i > 0) begin
        checks++;
        if (rf_we_wb_o !== 1'b1 || rf_waddr_wb_o !== addrs[i-1]) begin
          errors++;
          $display("[TB] FAIL b2b_write[%0d]: we=%0b addr=%0d, required 1/%0d", i, rf_we_wb_o, rf_waddr_wb_o, addrs[i-1]);
        end
      end
    end
    cyc();
    @(negedge clk_i);
    checks++;
    if (instr_cnt_o !== exp_cnt || rf_we_wb_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_count: cnt=%0d we=%0b, required %0d/0", instr_cnt_o, rf_we_wb_o, exp_cnt);
    end
  endtask

  task automatic test_load_latency();
    cyc();
    drive(1'b1, 2'b01, 5'd9, 32'h55, 1'b1);
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive(1'b1, 2'b00, 5'd12, 32'h77, 1'b1);
      @(negedge clk_i);
      checks++;
      if (ready_wb_o !== 1'b0 || outstanding_lsu_o !== 1'b1 || rf_we_lsu_o !== 1'b0 || rf_waddr_wb_o !== 5'd9) begin
        errors++;
        $display("[TB] FAIL load_wait[%0d]: ready=%0b outst=%0b lsu_we=%0b addr=%0d, required 0/1/0/9",
                 i, ready_wb_o, outstanding_lsu_o, rf_we_lsu_o, rf_waddr_wb_o);
      end
    end
    cyc();
    respond(1'b1, 1'b0, 32'hDEADBEEF);
    exp_q.push_back('{lsu: 1'b1, addr: 5'd9, data: 32'hDEADBEEF});
    exp_q.push_back('{lsu: 1'b0, addr: 5'd12, data: 32'h77});
    exp_cnt += 2;
    @(negedge clk_i);
    checks++;
    if (rf_we_lsu_o !== 1'b1 || rf_waddr_wb_o !== 5'd9 || rf_wdata_lsu_o !== 32'hDEADBEEF ||
        ready_wb_o !== 1'b1 || instr_done_wb_o !== 1'b1 || rf_wdata_wb_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL load_resp: we=%0b addr=%0d data=%h ready=%0b done=%0b wbdata=%h, required 1/9/deadbeef/1/1/0",
               rf_we_lsu_o, rf_waddr_wb_o, rf_wdata_lsu_o, ready_wb_o, instr_done_wb_o, rf_wdata_wb_o);
    end
    cyc();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    respond(1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (rf_we_wb_o !== 1'b1 || rf_waddr_wb_o !== 5'd12 || outstanding_lsu_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_follow: we=%0b addr=%0d outst=%0b, required 1/12/0", rf_we_wb_o, rf_waddr_wb_o, outstanding_lsu_o);
    end
    cyc();
    @(negedge clk_i);
    checks++;
    if (instr_cnt_o !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL load_count: got %0d, required %0d", instr_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_load_error();
    cyc();
    drive(1'b1, 2'b01, 5'd4, 32'h0, 1'b1);
    @(negedge clk_i);
    cyc();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    respond(1'b1, 1'b1, 32'h1234);
    exp_cnt++;
    @(negedge clk_i);
    checks++;
    if (rf_we_lsu_o !== 1'b0 || lsu_err_wb_o !== 1'b1 || instr_done_wb_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_err: we=%0b err=%0b done=%0b, required 0/1/1", rf_we_lsu_o, lsu_err_wb_o, instr_done_wb_o);
    end
    cyc();
    respond(1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (lsu_err_wb_o !== 1'b0 || instr_done_wb_o !== 1'b0 || instr_cnt_o !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL load_err_after: err=%0b done=%0b cnt=%0d, required 0/0/%0d",
               lsu_err_wb_o, instr_done_wb_o, instr_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_x0_store();
    cyc();
    drive(1'b1, 2'b00, 5'd0, 32'hABCD, 1'b1);
    exp_cnt++;
    @(negedge clk_i);
    cyc();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (rf_we_wb_o !== 1'b0 || instr_done_wb_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL x0_write: we=%0b done=%0b, required 0/1", rf_we_wb_o, instr_done_wb_o);
    end
    cyc();
    drive(1'b1, 2'b10, 5'd8, 32'h99, 1'b1);
    exp_cnt++;
    @(negedge clk_i);
    cyc();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    respond(1'b1, 1'b0, 32'h5A5A);
    @(negedge clk_i);
    checks++;
    if (rf_we_lsu_o !== 1'b0 || rf_we_wb_o !== 1'b0 || instr_done_wb_o !== 1'b1 || lsu_err_wb_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_nowrite: lsu_we=%0b wb_we=%0b done=%0b err=%0b, required 0/0/1/0",
               rf_we_lsu_o, rf_we_wb_o, instr_done_wb_o, lsu_err_wb_o);
    end
    cyc();
    respond(1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (instr_cnt_o !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL store_count: got %0d, required %0d", instr_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_spurious_and_reset();
    cyc();
    respond(1'b1, 1'b1, 32'h7777);
    @(negedge clk_i);
    checks++;
    if (lsu_err_wb_o !== 1'b0 || rf_we_lsu_o !== 1'b0 || instr_done_wb_o !== 1'b0 || outstanding_lsu_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spurious: err=%0b we=%0b done=%0b outst=%0b, required 0/0/0/0",
               lsu_err_wb_o, rf_we_lsu_o, instr_done_wb_o, outstanding_lsu_o);
    end
    cyc();
    respond(1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (instr_cnt_o !== exp_cnt || outstanding_lsu_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spurious_after: cnt=%0d outst=%0b, required %0d/0", instr_cnt_o, outstanding_lsu_o, exp_cnt);
    end
    cyc();
    drive(1'b1, 2'b01, 5'd10, 32'h0, 1'b1);
    @(negedge clk_i);
    cyc();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (outstanding_lsu_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_wait: outst=%0b, required 1", outstanding_lsu_o);
    end
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (outstanding_lsu_o !== 1'b0 || ready_wb_o !== 1'b1 || instr_cnt_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_wait_reset: outst=%0b ready=%0b cnt=%0d, required 0/1/0", outstanding_lsu_o, ready_wb_o, instr_cnt_o);
    end
    cyc();
    rst_i = 1'b0;
    exp_cnt = 32'd0;
    cyc();
    respond(1'b1, 1'b0, 32'hCAFE);
    @(negedge clk_i);
    checks++;
    if (rf_we_lsu_o !== 1'b0 || outstanding_lsu_o !== 1'b0 || instr_done_wb_o !== 1'b0 ||
        instr_cnt_o !== exp_cnt || ready_wb_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL late_resp: we=%0b outst=%0b done=%0b cnt=%0d ready=%0b, required 0/0/0/0/1",
               rf_we_lsu_o, outstanding_lsu_o, instr_done_wb_o, instr_cnt_o, ready_wb_o);
    end
    cyc();
    respond(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 32'd0;
    rst_i   = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    respond(1'b0, 1'b0, 32'h0);
    #2;
    test_reset();
    test_back_to_back();
    test_load_latency();
    test_load_error();
    test_x0_store();
    test_spurious_and_reset();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_wb_stage.md
Name: ibex_wb_stage

Overview:
- Single-entry writeback pipeline stage between ID/EX and the register file write/forward port.
- Holds one retiring instruction and drives the two RF write channels: writeback data for non-load results, LSU data for load results.
- Stalls ID/EX while a load/store waits for its LSU response.
- Counts retired instructions and flags LSU errors.

Parameters:
- DataWidth, 32, width of RF write data.
- CntWidth, 32, width of retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_wb_i  in  1  ID/EX presents an instruction to writeback this cycle.
- instr_type_wb_i  in  2  00 = reg-write ALU/CSR, 01 = load, 10 = store, 11 = no-write (branch/fence).
- rf_waddr_id_i  in  5  destination register.
- rf_wdata_id_i  in  DataWidth  ALU/CSR result.
- rf_we_id_i  in  1  instruction writes the RF.
- ready_wb_o  out  1  stage can accept a new instruction this cycle.
- lsu_resp_valid_i  in  1  LSU response for the outstanding load/store.
- lsu_resp_err_i  in  1  LSU response carries a bus error; qualified by lsu_resp_valid_i.
- rf_wdata_lsu_i  in  DataWidth  load data, valid with lsu_resp_valid_i.
- rf_waddr_wb_o  out  5  RF write address for both channels.
- rf_wdata_wb_o  out  DataWidth  writeback-channel data.
- rf_we_wb_o  out  1  writeback-channel write enable.
- rf_wdata_lsu_o  out  DataWidth  LSU-channel data.
- rf_we_lsu_o  out  1  LSU-channel write enable.
- outstanding_lsu_o  out  1  load/store in WB awaiting response.
- instr_done_wb_o  out  1  instruction retires this cycle.
- lsu_err_wb_o  out  1  retiring load/store got an error.
- instr_cnt_o  out  CntWidth  retired-instruction count.

Behaviour:
- Reset is asynchronous and active-high (rst_i). While rst_i is high:
  - state is EMPTY;
  - all held registers and instr_cnt_o are 0;
  - every output is 0 except ready_wb_o, which is 1.
- FSM states:
  - EMPTY: nothing held.
  - RETIRE: non-LSU instruction held.
  - LSU_WAIT: load/store held.
- Capture: when en_wb_i & ready_wb_o, register type, waddr, wdata and we at the clock edge. The next state is LSU_WAIT for types 01/10, otherwise RETIRE.
- Completion (done):
  - RETIRE is always done in its single cycle.
  - LSU_WAIT is done only in a cycle where lsu_resp_valid_i=1.
- Ready: ready_wb_o = (state==EMPTY) | done. This allows back-to-back retire plus capture in the same cycle with no bubble.
- Idle transition: when done with no capture, the next state is EMPTY.
- Writeback channel:
  - rf_we_wb_o = (state==RETIRE) & we_q & (waddr_q != 0).
  - rf_wdata_wb_o = wdata_q, and 0 when the held instruction is a load.
- LSU channel:
  - rf_we_lsu_o = (state==LSU_WAIT) & type_q==load & we_q & lsu_resp_valid_i & ~lsu_resp_err_i & (waddr_q != 0).
  - rf_wdata_lsu_o = rf_wdata_lsu_i combinationally, with zero added latency.
- rf_waddr_wb_o = waddr_q whenever the state is not EMPTY, else 0.
- outstanding_lsu_o = (state==LSU_WAIT).
- instr_done_wb_o = done; it is a one-cycle pulse per instruction.
- lsu_err_wb_o = (state==LSU_WAIT) & lsu_resp_valid_i & lsu_resp_err_i. On an error:
  - load write is suppressed;
  - the instruction still retires;
  - the counter still increments.
- Stores never write the RF, even if rf_we_id_i was 1.
- lsu_resp_valid_i outside LSU_WAIT is ignored: no write, no error, no state change.
- rf_we_wb_o and rf_we_lsu_o are never both 1 in the same cycle.
- instr_cnt_o increments by 1 on each done and wraps from all-ones to 0.
- en_wb_i while ready_wb_o=0: the instruction is not captured. ID/EX holds it, and the stage keeps its state.
- Reset mid-LSU_WAIT: the pending instruction is dropped. A response arriving after reset deassert is ignored because the stage is EMPTY.

Test Plan:
- Reset: assert rst_i mid-cycle → all outputs 0 immediately; ready_wb_o=1 and instr_cnt_o=0 after release.
- Back-to-back ALU: en_wb_i held 3 cycles with waddr 5/6/7 and wdata 0x11/0x22/0x33:
  - rf_we_wb_o high 3 consecutive cycles with matching address/data;
  - ready_wb_o stays 1;
  - instr_cnt_o=3.
- Load with 2-cycle latency: load to x9, response after 2 wait cycles with data 0xDEADBEEF:
  - ready_wb_o=0 and outstanding_lsu_o=1 for 2 cycles;
  - then rf_we_lsu_o=1, rf_waddr_wb_o=9, rf_wdata_lsu_o=0xDEADBEEF;
  - an ALU instruction offered in the response cycle is captured.
- Load error: load to x4 with response err=1 → rf_we_lsu_o=0, lsu_err_wb_o pulses once, instr_done_wb_o=1, counter +1.
- x0 and store: ALU write to x0 → rf_we_wb_o=0 with counter +1; store with rf_we_id_i=1 → no RF write on either channel.
- Spurious response and reset: lsu_resp_valid_i while EMPTY → no effect. rst_i pulsed during LSU_WAIT, then a late response → ignored, state EMPTY.
